// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: 16 streamed words in, one round per clock, chained H0..H7 out.
// Digest is presented NUM_ROUNDS+1 cycles after M[15]; input is stalled (blk_ready_o=0) while rounds run.
module sha256_round_engine #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [31:0]  blk_word_i,
    input  logic         blk_first_i,
    output logic         busy_o,
    output logic         digest_valid_o,
    output logic [255:0] digest_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_FINAL = 2'd3;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [5:0]   t_q, t_d;
    logic [31:0]  win_q  [16];
    logic [31:0]  win_d  [16];
    logic [31:0]  work_q [8];
    logic [31:0]  work_d [8];
    logic [31:0]  hash_q [8];
    logic [31:0]  hash_d [8];
    logic [31:0]  hsum   [8];
    logic [255:0] digest_q, digest_d, sum_flat;
    logic         xfer;
    logic [31:0]  w_t, s0_w, s1_w, big_s0, big_s1, ch, maj, t1, t2;

    assign blk_ready_o    = !reset_i && (state_q == S_IDLE || state_q == S_LOAD);
    assign busy_o         = (state_q != S_IDLE);
    assign digest_valid_o = (state_q == S_FINAL);
    assign xfer           = blk_valid_i && blk_ready_o;

    // The window shifts every round, so W[t-16], W[t-15], W[t-7], W[t-2] sit at fixed slots.
    always_comb begin
        s0_w   = ror(win_q[1], 7) ^ ror(win_q[1], 18) ^ (win_q[1] >> 3);
        s1_w   = ror(win_q[14], 17) ^ ror(win_q[14], 19) ^ (win_q[14] >> 10);
        w_t    = (t_q < 6'd16) ? win_q[0] : (s1_w + win_q[9] + s0_w + win_q[0]);
        big_s1 = ror(work_q[4], 6) ^ ror(work_q[4], 11) ^ ror(work_q[4], 25);
        ch     = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
        t1     = work_q[7] + big_s1 + ch + K_TAB[t_q] + w_t;
        big_s0 = ror(work_q[0], 2) ^ ror(work_q[0], 13) ^ ror(work_q[0], 22);
        maj    = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
        t2     = big_s0 + maj;
    end

    always_comb begin
        sum_flat = '0;
        for (int i = 0; i < 8; i++) begin
            hsum[i] = hash_q[i] + work_q[i];
            sum_flat[255 - 32*i -: 32] = hsum[i];
        end
    end

    // The digest is shown combinationally in FINAL so it is valid alongside the pulse.
    assign digest_o = (state_q == S_FINAL) ? sum_flat : digest_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        t_d      = t_q;
        digest_d = digest_q;
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
        for (int i = 0; i < 8; i++) begin
            work_d[i] = work_q[i];
            hash_d[i] = hash_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                    win_d[15] = blk_word_i;
                    cnt_d     = 4'd1;
                    state_d   = S_LOAD;
                    if (blk_first_i) begin
                        for (int i = 0; i < 8; i++) hash_d[i] = IV[i];
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                    win_d[15] = blk_word_i;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_ROUND;
                        t_d     = 6'd0;
                        for (int i = 0; i < 8; i++) work_d[i] = hash_q[i];
                    end
                end
            end
            S_ROUND: begin
                for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                win_d[15] = w_t;
                work_d[7] = work_q[6];
                work_d[6] = work_q[5];
                work_d[5] = work_q[4];
                work_d[4] = work_q[3] + t1;
                work_d[3] = work_q[2];
                work_d[2] = work_q[1];
                work_d[1] = work_q[0];
                work_d[0] = t1 + t2;
                t_d       = t_q + 6'd1;
                if (t_q == 6'(NUM_ROUNDS - 1)) state_d = S_FINAL;
            end
            default: begin
                for (int i = 0; i < 8; i++) hash_d[i] = hsum[i];
                digest_d = sum_flat;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            t_q      <= '0;
            digest_q <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                hash_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            digest_q <= digest_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= work_d[i];
                hash_q[i] <= hash_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer digests, latency, reset abort, input stall.
module tb_sha256_round_engine;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [31:0]  blk_word_i;
    logic         blk_first_i;
    logic         busy_o;
    logic         digest_valid_o;
    logic [255:0] digest_o;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    sha256_round_engine #(.NUM_ROUNDS(64)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .blk_valid_i    (blk_valid_i),
        .blk_ready_o    (blk_ready_o),
        .blk_word_i     (blk_word_i),
        .blk_first_i    (blk_first_i),
        .busy_o         (busy_o),
        .digest_valid_o (digest_valid_o),
        .digest_o       (digest_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
    task automatic send_word(input logic [31:0] w, input logic first);
        int guard;
        guard       = 0;
        blk_valid_i = 1'b1;
        blk_word_i  = w;
        blk_first_i = first;
        while (!blk_ready_o && guard < 300) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!blk_ready_o) check("word_accept_timeout", {255'd0, blk_ready_o}, 256'd1);
        @(posedge clk_i); #1;
        blk_valid_i = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] blk [16], input logic first, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk_i); #1;
                end
            end
            // blk_first on M[1..15] is driven opposite to M[0] to show it is ignored there.
            send_word(blk[i], (i == 0) ? first : ~first);
        end
    endtask

    // n counts cycles after the M[15] transfer cycle; n == 65 means digest_valid in cycle L+65.
    task automatic wait_digest(output int n, output bit rdy_seen);
        n        = 0;
        rdy_seen = 1'b0;
        while (n < 300) begin
            n++;
            if (digest_valid_o) break;
            if (blk_ready_o) rdy_seen = 1'b1;
            @(posedge clk_i); #1;
        end
    endtask

    logic [31:0] abc_blk   [16];
    logic [31:0] empty_blk [16];
    logic [31:0] two1_blk  [16];
    logic [31:0] two2_blk  [16];
    int          n;
    bit          rdy_seen;
    bit          dv_seen;

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc_blk[i]   = 32'h0;
            empty_blk[i] = 32'h0;
            two2_blk[i]  = 32'h0;
        end
        abc_blk[0]   = 32'h61626380;
        abc_blk[15]  = 32'h00000018;
        empty_blk[0] = 32'h80000000;
        two2_blk[15] = 32'h000001c0;
        two1_blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};

        reset_i     = 1'b1;
        blk_valid_i = 1'b0;
        blk_word_i  = 32'h0;
        blk_first_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_digest", digest_o, 256'd0);
        check("reset_busy", {255'd0, busy_o}, 256'd0);
        check("reset_dvalid", {255'd0, digest_valid_o}, 256'd0);
        check("reset_ready", {255'd0, blk_ready_o}, 256'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle_ready", {255'd0, blk_ready_o}, 256'd1);

        // "abc" single block
        send_block(abc_blk, 1'b1, 1'b0);
        check("round_busy", {255'd0, busy_o}, 256'd1);
        wait_digest(n, rdy_seen);
        check("abc_latency", 256'(n), 256'd65);
        check("abc_digest", digest_o, D_ABC);
        @(posedge clk_i); #1;
        check("abc_pulse_one_cycle", {255'd0, digest_valid_o}, 256'd0);
        check("abc_digest_held", digest_o, D_ABC);
        check("abc_idle_busy", {255'd0, busy_o}, 256'd0);

        // empty message
        send_block(empty_blk, 1'b1, 1'b0);
        wait_digest(n, rdy_seen);
        check("empty_digest", digest_o, D_EMPTY);
        @(posedge clk_i); #1;

        // two-block chained message
        send_block(two1_blk, 1'b1, 1'b0);
        wait_digest(n, rdy_seen);
        @(posedge clk_i); #1;
        send_block(two2_blk, 1'b0, 1'b0);
        wait_digest(n, rdy_seen);
        check("two_block_digest", digest_o, D_TWO);
        @(posedge clk_i); #1;

        // "abc" with random gaps in blk_valid during LOAD
        send_block(abc_blk, 1'b1, 1'b1);
        wait_digest(n, rdy_seen);
        check("gap_latency", 256'(n), 256'd65);
        check("gap_digest", digest_o, D_ABC);
        @(posedge clk_i); #1;

        // reset asserted at round t=30
        send_block(abc_blk, 1'b1, 1'b0);
        repeat (30) begin
            @(posedge clk_i); #1;
        end
        check("pre_abort_busy", {255'd0, busy_o}, 256'd1);
        reset_i = 1'b1;
        #1;
        check("abort_digest", digest_o, 256'd0);
        check("abort_busy", {255'd0, busy_o}, 256'd0);
        check("abort_ready", {255'd0, blk_ready_o}, 256'd0);
        dv_seen = 1'b0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (digest_valid_o) dv_seen = 1'b1;
        end
        check("abort_no_pulse", {255'd0, dv_seen}, 256'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        send_block(abc_blk, 1'b1, 1'b0);
        wait_digest(n, rdy_seen);
        check("post_abort_digest", digest_o, D_ABC);
        @(posedge clk_i); #1;

        // blk_valid held through ROUND with the next block's M[0] waiting
        send_block(abc_blk, 1'b1, 1'b0);
        blk_valid_i = 1'b1;
        blk_word_i  = empty_blk[0];
        blk_first_i = 1'b1;
        wait_digest(n, rdy_seen);
        check("hold_ready_low_in_round", {255'd0, rdy_seen}, 256'd0);
        check("hold_abc_digest", digest_o, D_ABC);
        check("hold_latency", 256'(n), 256'd65);
        @(posedge clk_i); #1;
        check("hold_ready_after_pulse", {255'd0, blk_ready_o}, 256'd1);
        @(posedge clk_i); #1;
        check("hold_m0_accepted", {255'd0, busy_o}, 256'd1);
        for (int i = 1; i < 16; i++) send_word(empty_blk[i], 1'b0);
        wait_digest(n, rdy_seen);
        check("hold_next_digest", digest_o, D_EMPTY);
        @(posedge clk_i); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
